// File: rtl/dmi_host_ctrl_pkg.sv
// rtl/dmi_host_ctrl_pkg.sv - shared DMI types plus op, response, status and FSM state encodings
// Purpose: types shared by dmi_host_ctrl, its DMI interface and the bench.
// Contents: dmi_req_t {addr, op, data}, dmi_resp_t {data, resp}, DMI op and
//           response codes, host status enum, host FSM state enum and the
//           helper that maps a final DMI response code onto a host status.
package dmi_host_ctrl_pkg;

   localparam logic [1:0] DMI_OP_NOP   = 2'd0;
   localparam logic [1:0] DMI_OP_READ  = 2'd1;
   localparam logic [1:0] DMI_OP_WRITE = 2'd2;

   localparam logic [1:0] DMI_RESP_OK     = 2'd0;
   localparam logic [1:0] DMI_RESP_FAILED = 2'd2;
   localparam logic [1:0] DMI_RESP_BUSY   = 2'd3;

   typedef struct packed {
      logic [6:0]  addr;
      logic [1:0]  op;
      logic [31:0] data;
   } dmi_req_t;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
   } dmi_resp_t;

   typedef enum logic [1:0] {
      RSP_OK             = 2'd0,
      RSP_TIMEOUT        = 2'd1,
      RSP_FAILED         = 2'd2,
      RSP_BUSY_EXHAUSTED = 2'd3
   } rsp_status_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT_RSP,
      S_GAP,
      S_DONE
   } host_state_e;

   // Only called for a response that ends the transaction, so busy here
   // always means the retry budget is spent. The reserved code 1 is
   // reported as a failure.
   function automatic rsp_status_e resp_to_status(input logic [1:0] resp);
      case (resp)
         DMI_RESP_OK:   return RSP_OK;
         DMI_RESP_BUSY: return RSP_BUSY_EXHAUSTED;
         default:       return RSP_FAILED;
      endcase
   endfunction

endpackage

// File: rtl/dmi_host_ctrl_if.sv
// rtl/dmi_host_ctrl_if.sv - DMI initiator/target bundle with master and slave modports
// Purpose: groups the DMI request/response handshake signals.
// Signals (directions as seen by the host controller, the master):
//   dmi_req_o        request payload {addr, op, data}
//   dmi_req_valid_o  request valid
//   dmi_req_ready_i  request accepted by the target
//   dmi_resp_i       response payload {data, resp}
//   dmi_resp_valid_i response valid
//   dmi_resp_ready_o response accepted by the host
interface dmi_host_ctrl_if;
   import dmi_host_ctrl_pkg::*;

   dmi_req_t  dmi_req_o;
   logic      dmi_req_valid_o;
   logic      dmi_req_ready_i;
   dmi_resp_t dmi_resp_i;
   logic      dmi_resp_valid_i;
   logic      dmi_resp_ready_o;

   modport master (
      output dmi_req_o, dmi_req_valid_o, dmi_resp_ready_o,
      input  dmi_req_ready_i, dmi_resp_i, dmi_resp_valid_i
   );

   modport slave (
      input  dmi_req_o, dmi_req_valid_o, dmi_resp_ready_o,
      output dmi_req_ready_i, dmi_resp_i, dmi_resp_valid_i
   );

endinterface

// File: rtl/dmi_host_ctrl.sv
// rtl/dmi_host_ctrl.sv - DMI host controller with busy retry, response timeout and stale-response drain
// Purpose: takes one debugger command at a time, issues it on the DMI, retries
//          busy responses after an idle gap, times out silent targets and
//          returns a status/data result to the debugger.
// Ports: clk_i, rst_ni (async, active low)
//        cmd_valid_i/cmd_ready_o, cmd_op_i, cmd_addr_i, cmd_data_i   debugger command
//        rsp_valid_o/rsp_ready_i, rsp_data_o, rsp_status_o           debugger result
//        dmi (dmi_host_ctrl_if.master)                               DMI initiator side
//        busy_o                                                      high outside IDLE
//        stat_txn_o, stat_err_o                                      only with DMI_HOST_STATS_EN
// Option: define DMI_HOST_STATS_EN to add 16-bit saturating transaction and
//         error counters.
module dmi_host_ctrl
   import dmi_host_ctrl_pkg::*;
#(
   parameter int unsigned TimeoutCycles = 1024,
   parameter int unsigned MaxRetries    = 4,
   parameter int unsigned RetryGap      = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         cmd_valid_i,
   output logic         cmd_ready_o,
   input  logic [1:0]   cmd_op_i,
   input  logic [6:0]   cmd_addr_i,
   input  logic [31:0]  cmd_data_i,
   output logic         rsp_valid_o,
   input  logic         rsp_ready_i,
   output logic [31:0]  rsp_data_o,
   output logic [1:0]   rsp_status_o,
   dmi_host_ctrl_if.master dmi,
   output logic         busy_o
`ifdef DMI_HOST_STATS_EN
   ,
   output logic [15:0]  stat_txn_o,
   output logic [15:0]  stat_err_o
`endif
);

   // Counter compare points; the counter starts at 0 on entry to a state,
   // so the state lasts exactly N cycles when it leaves at N-1.
   localparam logic [31:0] TO_LAST   = 32'(TimeoutCycles - 1);
   localparam logic [31:0] GAP_LAST  = 32'(RetryGap - 1);
   localparam logic [31:0] RETRY_MAX = 32'(MaxRetries);

   host_state_e r_state;
   host_state_e w_state_nxt;
   dmi_req_t    r_req;
   logic [31:0] r_cnt;
   logic [31:0] r_retry;
   logic [31:0] r_rsp_data;
   rsp_status_e r_rsp_status;

   logic        w_load_rsp;
   rsp_status_e w_status_nxt;
   logic [31:0] w_data_nxt;
   logic        w_retry;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt          = r_state;
      cmd_ready_o          = 1'b0;
      rsp_valid_o          = 1'b0;
      dmi.dmi_req_valid_o  = 1'b0;
      dmi.dmi_resp_ready_o = 1'b0;
      w_load_rsp           = 1'b0;
      w_status_nxt         = RSP_OK;
      w_data_nxt           = '0;
      w_retry              = 1'b0;

      case (r_state)
         S_IDLE: begin
            cmd_ready_o = 1'b1;
            // Always accept here so a response that arrives after a timeout
            // is drained instead of blocking the target.
            dmi.dmi_resp_ready_o = 1'b1;
            if (cmd_valid_i) begin
               w_state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            dmi.dmi_req_valid_o = 1'b1;
            if (dmi.dmi_req_ready_i) begin
               w_state_nxt = S_WAIT_RSP;
            end
         end
         S_WAIT_RSP: begin
            dmi.dmi_resp_ready_o = 1'b1;
            // A response in the final counted cycle takes priority over the timeout.
            if (dmi.dmi_resp_valid_i) begin
               if (dmi.dmi_resp_i.resp == DMI_RESP_BUSY && r_retry < RETRY_MAX) begin
                  w_retry     = 1'b1;
                  w_state_nxt = (RetryGap == 0) ? S_REQ : S_GAP;
               end else begin
                  w_load_rsp   = 1'b1;
                  w_status_nxt = resp_to_status(dmi.dmi_resp_i.resp);
                  if (dmi.dmi_resp_i.resp == DMI_RESP_OK && r_req.op == DMI_OP_READ) begin
                     w_data_nxt = dmi.dmi_resp_i.data;
                  end
                  w_state_nxt = S_DONE;
               end
            end else if (r_cnt == TO_LAST) begin
               w_load_rsp   = 1'b1;
               w_status_nxt = RSP_TIMEOUT;
               w_state_nxt  = S_DONE;
            end
         end
         S_GAP: begin
            if (r_cnt == GAP_LAST) begin
               w_state_nxt = S_REQ;
            end
         end
         S_DONE: begin
            rsp_valid_o = 1'b1;
            if (rsp_ready_i) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_req        <= '0;
         r_cnt        <= '0;
         r_retry      <= '0;
         r_rsp_data   <= '0;
         r_rsp_status <= RSP_OK;
      end else begin
         if (r_state == S_IDLE && cmd_valid_i) begin
            r_req   <= '{addr: cmd_addr_i, op: cmd_op_i, data: cmd_data_i};
            r_retry <= '0;
         end
         // One counter serves both the response timeout and the retry gap;
         // it restarts on every state change, i.e. on every attempt.
         if (w_state_nxt != r_state) begin
            r_cnt <= '0;
         end else if (r_state == S_WAIT_RSP || r_state == S_GAP) begin
            r_cnt <= r_cnt + 32'd1;
         end
         if (w_retry) begin
            r_retry <= r_retry + 32'd1;
         end
         if (w_load_rsp) begin
            r_rsp_data   <= w_data_nxt;
            r_rsp_status <= w_status_nxt;
         end
      end
   end

   assign dmi.dmi_req_o = r_req;
   assign rsp_data_o    = r_rsp_data;
   assign rsp_status_o  = r_rsp_status;
   assign busy_o        = (r_state != S_IDLE);

`ifdef DMI_HOST_STATS_EN
   logic [15:0] r_stat_txn;
   logic [15:0] r_stat_err;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_stat_txn <= '0;
         r_stat_err <= '0;
      end else if (r_state == S_DONE && rsp_ready_i) begin
         if (r_stat_txn != 16'hFFFF) begin
            r_stat_txn <= r_stat_txn + 16'd1;
         end
         if (r_rsp_status != RSP_OK && r_stat_err != 16'hFFFF) begin
            r_stat_err <= r_stat_err + 16'd1;
         end
      end
   end

   assign stat_txn_o = r_stat_txn;
   assign stat_err_o = r_stat_err;
`endif

endmodule
